// File: rtl/div_sched_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_sched_ctrl                                                       |
// | Programmable clock divider with a shadow config applied on wraps.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_sched_ctrl #(
  parameter int CNT_W      = 16,
  parameter int RST_PERIOD = 60,
  parameter int RST_HIGH   = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             o_clk,
  output logic             o_tick,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic [CNT_W-1:0] sh_period_q, sh_period_d;
  logic [CNT_W-1:0] sh_high_q, sh_high_d;
  logic             pend_q, pend_d;
  logic             o_clk_q, o_clk_d;
  logic             cfg_err_q, cfg_err_d;

  logic accept;
  logic cfg_bad;
  logic wrap;

  assign cfg_ready = !pend_q;
  assign accept    = cfg_valid && !pend_q;
  assign cfg_bad   = (cfg_period == '0) || (cfg_high == '0) || (cfg_high > cfg_period);
  assign wrap      = (state_q != IDLE) && (cnt_q == act_period_q);

  assign o_clk   = o_clk_q;
  assign o_tick  = wrap;
  assign busy    = (state_q != IDLE);
  assign cfg_err = cfg_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_period_d = act_period_q;
    act_high_d   = act_high_q;
    sh_period_d  = sh_period_q;
    sh_high_d    = sh_high_q;
    pend_d       = pend_q;
    o_clk_d      = o_clk_q;
    cfg_err_d    = accept && cfg_bad;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        o_clk_d = 1'b0;
        // A config shadowed on the final drain wrap is applied here.
        if (pend_q) begin
          act_period_d = sh_period_q;
          act_high_d   = sh_high_q;
          pend_d       = 1'b0;
        end
        if (accept && !cfg_bad) begin
          act_period_d = cfg_period;
          act_high_d   = cfg_high;
        end
        if (en) state_d = RUN;
      end
      RUN, DRAIN: begin
        cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
        o_clk_d = (cnt_q < act_high_q);
        if (wrap && pend_q) begin
          act_period_d = sh_period_q;
          act_high_d   = sh_high_q;
          pend_d       = 1'b0;
        end
        // Shadow load after the apply, so a wrap-edge offer waits a period.
        if (accept && !cfg_bad) begin
          sh_period_d = cfg_period;
          sh_high_d   = cfg_high;
          pend_d      = 1'b1;
        end
        if (state_q == RUN) begin
          if (!en) state_d = DRAIN;
        end else if (en) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
          cnt_d   = '0;
          o_clk_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        o_clk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      act_period_q <= CNT_W'(RST_PERIOD);
      act_high_q   <= CNT_W'(RST_HIGH);
      sh_period_q  <= '0;
      sh_high_q    <= '0;
      pend_q       <= 1'b0;
      o_clk_q      <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_period_q <= act_period_d;
      act_high_q   <= act_high_d;
      sh_period_q  <= sh_period_d;
      sh_high_q    <= sh_high_d;
      pend_q       <= pend_d;
      o_clk_q      <= o_clk_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

endmodule
`default_nettype wire
